fetch_queue: RTL and testbench

//   Instruction fetch buffer between the instruction-fetch unit and the decode stage.

---
 rtl/cpu_defs_pkg.sv | 6 +
 rtl/fq_storage.sv | 27 ++
 rtl/fetch_queue.sv | 79 +++++++
 tb/tb_fetch_queue.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU word width and reset/nop constants
package cpu_defs;
    localparam int          WORD_W    = 32;
    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
endpackage

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - DEPTH x 2W register file, one write port, one async read port
module fq_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wpc,
    input  logic [W-1:0]  i_winstr,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rpc,
    output logic [W-1:0]  o_rinstr
);
    // Payload needs no reset: an entry is only read once count covers it.
    logic [2*W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= {i_wpc, i_winstr};
        end
    end

    assign o_rpc    = r_mem[i_raddr][2*W-1:W];
    assign o_rinstr = r_mem[i_raddr][W-1:0];
endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order {pc,instr} buffer between fetch and decode with flush
module fetch_queue
    import cpu_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = WORD_W,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_pc,
    input  logic [W-1:0]  in_instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_pc,
    output logic [W-1:0]  out_instr,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;
    logic [W-1:0]  w_rd_pc;
    logic [W-1:0]  w_rd_instr;

    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_storage (
        .clk      (clk),
        .i_we     (w_push & ~flush),
        .i_waddr  (r_tail),
        .i_wpc    (in_pc),
        .i_winstr (in_instr),
        .i_raddr  (r_head),
        .o_rpc    (w_rd_pc),
        .o_rinstr (w_rd_instr)
    );

    // Empty queue drives zero so decode sees a nop rather than stale payload.
    assign out_pc    = out_valid ? w_rd_pc : W'(INSTR_NOP);
    assign out_instr = out_valid ? w_rd_instr : W'(INSTR_NOP);
    assign count     = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed scoreboard bench for fetch_queue
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_pc;
    logic [W-1:0]  in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_pc;
    logic [W-1:0]  out_instr;
    logic [CW-1:0] count;

    int passed = 0;
    int total  = 0;
    logic [2*W-1:0] sb [$];

    fetch_queue #(.DEPTH(DEPTH), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk_instr(input logic [W-1:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus: check the pre-edge view, update the model, check post-edge.
    task automatic cycle(input logic v, input logic [W-1:0] pc, input logic rdy, input logic fl);
        logic [2*W-1:0] head;
        logic do_push;
        logic do_pop;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = mk_instr(pc);
        out_ready = rdy;
        flush     = fl;
        #1;
        chk("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
        chk("out_valid_pre", 64'(out_valid), 64'(sb.size() != 0));
        do_push = v && (sb.size() != DEPTH);
        do_pop  = rdy && (sb.size() != 0);
        if (sb.size() != 0) begin
            head = sb[0];
            chk("head_pc", 64'(out_pc), 64'(head[2*W-1:W]));
            chk("head_instr", 64'(out_instr), 64'(head[W-1:0]));
        end else begin
            chk("empty_pc", 64'(out_pc), 64'h0);
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back({pc, mk_instr(pc)});
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        chk("count", 64'(count), 64'(sb.size()));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    endtask

    task automatic drain();
        while (sb.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        #2;
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_out_pc", 64'(out_pc), 64'h0);
        reset = 1'b0;
        tick();

        // Stream: fill three, then pop in order
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3000 + 32'(4*i), 1'b0, 1'b0);
        chk("stream_count", 64'(count), 64'd3);
        chk("stream_head", 64'(out_pc), 64'h3000);
        drain();
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Full: fifth push rejected even while popping
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h3000 + 32'(4*i), 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'h0);
        cycle(1'b1, 32'h3010, 1'b1, 1'b0);
        chk("full_reject_count", 64'(count), 64'd3);
        drain();

        // Simultaneous push/pop with pointer wrap
        cycle(1'b1, 32'h3018, 1'b0, 1'b0);
        cycle(1'b1, 32'h301C, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 32'h3020 + 32'(4*i), 1'b1, 1'b0);
            chk("simul_count", 64'(count), 64'd2);
        end
        drain();

        // Flush overrides push and pop
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3100 + 32'(4*i), 1'b0, 1'b0);
        cycle(1'b1, 32'h4000, 1'b1, 1'b1);
        chk("flush_count", 64'(count), 64'h0);
        cycle(1'b1, 32'h4004, 1'b0, 1'b0);
        chk("post_flush_head", 64'(out_pc), 64'h4004);
        drain();

        // Asynchronous reset between edges
        cycle(1'b1, 32'h5000, 1'b0, 1'b0);
        cycle(1'b1, 32'h5004, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_count", 64'(count), 64'h0);
        chk("async_rst_valid", 64'(out_valid), 64'h0);
        reset = 1'b0;
        sb.delete();
        cycle(1'b1, 32'h5008, 1'b0, 1'b0);
        chk("post_rst_head", 64'(out_pc), 64'h5008);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
